// File: rtl/seq_pulse_pkg.sv
// seq_pulse_pkg: shared state encoding and configuration constants for the sequential pulse generator
package seq_pulse_pkg;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   localparam logic MODE_CONT   = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;
   localparam logic DIR_DOWN    = 1'b0;
   localparam logic DIR_UP      = 1'b1;
endpackage

// File: rtl/seq_dwell_cnt.sv
// seq_dwell_cnt: slot dwell counter, ticks on the enabled cycle where it reaches the limit
module seq_dwell_cnt #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [DWELL_W-1:0] limit,
   output logic               tick
);
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   always_comb begin
      tick  = (cnt_q == limit) && en;
      cnt_d = (clr || tick) ? '0 : en ? cnt_q + DWELL_W'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/seq_pulse_gen_param.sv
// seq_pulse_gen_param: N-channel one-hot pulse sequencer with dwell, direction, single-shot, pause and abort
module seq_pulse_gen_param
   import seq_pulse_pkg::*;
#(
   parameter  int N       = 4,
   parameter  int DWELL_W = 8,
   localparam int IDX_W   = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               en,
   input  logic               mode,
   input  logic               dir,
   input  logic [DWELL_W-1:0] dwell,
   output logic [N-1:0]       q,
   output logic [IDX_W-1:0]   idx,
   output logic               busy,
   output logic               done
);
   localparam logic [IDX_W-1:0] TOP = IDX_W'(N - 1);
   state_t             state_q, state_d;
   logic               mode_q, mode_d, dir_q, dir_d, done_q, done_d, tick;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N-1:0]       q_q, q_d;

   seq_dwell_cnt #(.DWELL_W(DWELL_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (state_q != RUN),
      .en    ((state_q == RUN) && en),
      .limit (dwell_q),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      dwell_d = dwell_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      if (state_q == RUN) begin
         if (stop) state_d = IDLE;
         else if (tick) begin
            if (idx_q == ((dir_q == DIR_UP) ? TOP : '0)) begin
               if (mode_q == MODE_SINGLE) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else idx_d = (dir_q == DIR_UP) ? '0 : TOP;
            end else idx_d = (dir_q == DIR_UP) ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
         end
      end else begin
         state_d = IDLE;
         if (start && !stop) begin
            state_d = RUN;
            mode_d  = mode ? MODE_SINGLE : MODE_CONT;
            dir_d   = dir;
            dwell_d = dwell;
            idx_d   = (dir == DIR_DOWN) ? TOP : '0;
         end
      end
      if (state_d != RUN) idx_d = '0;
      q_d = (state_d == RUN) ? {{(N-1){1'b0}}, 1'b1} << idx_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         dir_q   <= 1'b0;
         dwell_q <= '0;
         idx_q   <= '0;
         q_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
         q_q     <= q_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign idx  = idx_q;
   assign busy = (state_q == RUN);
   assign done = done_q;
endmodule

// File: tb/tb_seq_pulse_gen_param.sv
// tb_seq_pulse_gen_param: two instances (N=4/DWELL_W=8, N=8/DWELL_W=4) checked against a slot-ordinal model
module tb_seq_pulse_gen_param;
   logic clk = 1'b0;
   logic rst, start, stop, en, mode, dir;
   logic [7:0] dwell;
   logic [3:0] q4;
   logic [1:0] idx4;
   logic       busy4, done4;
   logic [7:0] q8;
   logic [2:0] idx8;
   logic       busy8, done8;
   int tests = 0, fails = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   seq_pulse_gen_param #(.N(4), .DWELL_W(8)) u4 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode), .dir(dir),
      .dwell(dwell), .q(q4), .idx(idx4), .busy(busy4), .done(done4));
   seq_pulse_gen_param #(.N(8), .DWELL_W(4)) u8 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode), .dir(dir),
      .dwell(dwell[3:0]), .q(q8), .idx(idx8), .busy(busy8), .done(done8));

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model tracks the slot ordinal (0 = first channel visited) and cycles spent in it.
   int  nn[2] = '{4, 8};
   bit  m_run[2], m_mode[2], m_dir[2], m_done[2];
   int  slot[2], el[2], m_dw[2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (rst) begin
            m_run[i] = 1'b0;
            slot[i]  = 0;
            el[i]    = 0;
         end else if (m_run[i]) begin
            if (stop) m_run[i] = 1'b0;
            else if (en) begin
               if (el[i] == m_dw[i]) begin
                  el[i] = 0;
                  if (slot[i] == nn[i] - 1) begin
                     if (m_mode[i]) begin
                        m_run[i]  = 1'b0;
                        m_done[i] = 1'b1;
                     end else slot[i] = 0;
                  end else slot[i]++;
               end else el[i]++;
            end
         end else if (start && !stop) begin
            m_run[i]  = 1'b1;
            slot[i]   = 0;
            el[i]     = 0;
            m_mode[i] = mode;
            m_dir[i]  = dir;
            m_dw[i]   = (i == 0) ? int'(dwell) : int'(dwell[3:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 2; i++) begin
            int ex_idx, ex_q, aq, ai, ab, ad;
            ex_idx = m_run[i] ? (m_dir[i] ? slot[i] : nn[i] - 1 - slot[i]) : 0;
            ex_q   = m_run[i] ? (1 << ex_idx) : 0;
            aq = (i == 0) ? int'(q4) : int'(q8);
            ai = (i == 0) ? int'(idx4) : int'(idx8);
            ab = (i == 0) ? int'(busy4) : int'(busy8);
            ad = (i == 0) ? int'(done4) : int'(done8);
            chk($sformatf("model_q[%0d]", i), aq, ex_q);
            chk($sformatf("model_idx[%0d]", i), ai, ex_idx);
            chk($sformatf("model_busy[%0d]", i), ab, int'(m_run[i]));
            chk($sformatf("model_done[%0d]", i), ad, int'(m_done[i]));
            chk($sformatf("onehot[%0d]", i), int'(ab != 0 ? $onehot(aq) : (aq == 0)), 1);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      int n;
      int exp_q1[5]   = '{8, 4, 2, 1, 8};
      int exp_idx1[5] = '{3, 2, 1, 0, 3};
      rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b1; mode = 1'b0; dir = 1'b0; dwell = 8'd0;
      cyc(); cyc();
      rst = 1'b0;
      chk_on = 1'b1;
      chk("reset_q", int'(q4), 0);
      chk("reset_idx", int'(idx4), 0);
      chk("reset_busy", int'(busy4), 0);
      chk("reset_done", int'(done4), 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("cont_q", int'(q4), exp_q1[k]);
         chk("cont_idx", int'(idx4), exp_idx1[k]);
         chk("cont_busy", int'(busy4), 1);
         cyc();
      end
      chk("pause_pre", int'(q4), 4);
      en = 1'b0; dwell = 8'd5; dir = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("pause_hold", int'(q4), 4);
         chk("pause_busy", int'(busy4), 1);
      end
      en = 1'b1;
      cyc();
      chk("pause_resume", int'(q4), 2);
      stop = 1'b1;
      cyc();
      chk("abort_q", int'(q4), 0);
      chk("abort_busy", int'(busy4), 0);
      chk("abort_done", int'(done4), 0);
      start = 1'b1;
      cyc();
      chk("start_stop_idle", int'(busy4), 0);
      start = 1'b0; stop = 1'b0;
      dwell = 8'd2; mode = 1'b1; dir = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         chk("single_q", int'(q4), 1 << (k / 3));
         cyc();
      end
      chk("single_end_q", int'(q4), 0);
      chk("single_end_busy", int'(busy4), 0);
      chk("single_done", int'(done4), 1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("done_restart_busy", int'(busy4), 1);
      chk("done_restart_q", int'(q4), 1);
      chk("done_once", int'(done4), 0);
      stop = 1'b1; cyc(); stop = 1'b0;
      mode = 1'b0; dir = 1'b0; dwell = 8'd3; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_mid_q", int'(q4), 0);
      chk("rst_mid_idx", int'(idx4), 0);
      chk("rst_mid_busy", int'(busy4), 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("rst_restart_dwell", int'(q4), 8);
         cyc();
      end
      chk("rst_restart_next", int'(q4), 4);
      stop = 1'b1; cyc(); stop = 1'b0;
      dwell = 8'd15; mode = 1'b1; dir = 1'b0; start = 1'b1;
      cyc();
      start = 1'b0;
      chk("n8_first", int'(q8), 8'h80);
      n = 0;
      while (busy8 && n < 300) begin
         n++;
         cyc();
      end
      chk("n8_busy_len", n, 128);
      chk("n8_done", int'(done8), 1);
      cyc();
      chk("n8_done_once", int'(done8), 0);
      for (int k = 0; k < 3000; k++) begin
         rst   = ($urandom_range(0, 499) == 0);
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 63) == 0);
         en    = ($urandom_range(0, 7) != 0);
         mode  = 1'($urandom);
         dir   = 1'($urandom);
         dwell = 8'($urandom_range(0, 3));
         cyc();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_pulse_gen_param.md
Name: seq_pulse_gen_param

Overview:
Parametrised N-channel sequential (one-hot) pulse generator. It drives exactly one of N outputs high at a time and steps through all channels in order.
- Programmable dwell per slot, shift direction, continuous or single-shot mode, pause, and abort.
- Successor to the fixed 4-bit 1000→0100→0010→0001 generator.
- Used as a timing/strobe source for scanning and multiplexing logic.

Parameters:
N, 4, number of output channels (N >= 2).
DWELL_W, 8, width of dwell setting; each slot lasts dwell+1 cycles.
IDX_W, $clog2(N), width of slot index output (derived, not overridden).

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  pulse; starts a sequence when in IDLE.
stop  in  1  synchronous abort; returns to IDLE.
en  in  1  advance enable; 0 freezes sequence (pause).
mode  in  1  0 = continuous (wrap), 1 = single-shot.
dir  in  1  0 = MSB→LSB (bit N-1 first), 1 = LSB→MSB (bit 0 first).
dwell  in  DWELL_W  slot length minus one, in cycles.
q  out  N  one-hot pulse outputs; all-zero when idle.
idx  out  IDX_W  bit position of the active q bit; 0 when idle.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse at end of a single-shot sequence.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at an edge):
  - Outputs after that edge: q=0, idx=0, busy=0, done=0.
  - Internal state: FSM=IDLE, dwell counter=0.
  - Reset overrides all other inputs.
  - Reset mid-sequence has identical effect; no done pulse.
- FSM states:
  - IDLE: q=0. start=1 → RUN at the next edge.
  - RUN: on that same edge, mode, dir and dwell are latched. Input changes during RUN are ignored.
- Start latency: start sampled at edge k → after edge k, q holds the first channel, busy=1, counter=0.
  - dir=0 first channel: bit N-1.
  - dir=1 first channel: bit 0.
- Slot timing:
  - The counter increments on each edge with en=1.
  - When counter==dwell_lat and en=1, the edge advances to the next channel and clears the counter.
  - Each slot therefore lasts dwell_lat+1 enabled cycles; dwell=0 gives one channel per cycle.
- Pause: en=0 holds q, idx and counter unchanged; busy stays 1.
- Advance on the last channel (bit 0 for dir=0, bit N-1 for dir=1):
  - Continuous: wrap to the first channel, with no gap cycle.
  - Single-shot: go to IDLE. After the edge q=0, busy=0, done=1 for exactly one cycle.
- Abort: stop=1 in RUN → IDLE at that edge; q=0, busy=0, no done. stop in IDLE has no effect.
- Simultaneous inputs:
  - stop and start together: stop wins, stays/goes IDLE.
  - start during RUN: ignored.
  - start in the same cycle done is high: accepted (FSM already IDLE).
- Invariant: q is one-hot in RUN and zero in IDLE. idx always equals the position of the set bit.
- Illegal state encodings recover to IDLE with q=0.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package seq_pulse_pkg holds:
  - state enum {IDLE, RUN};
  - MODE_CONT=0, MODE_SINGLE=1;
  - DIR_DOWN=0, DIR_UP=1.
- One sub-module, seq_dwell_cnt:
  - DWELL_W-bit counter with inputs clr, en, limit;
  - output tick = (cnt==limit)&en.
- The top level holds the FSM, the config latch and the one-hot shifter/index register.

Test Plan:
1. N=4, dwell=0, mode=0, dir=0, en=1, start pulse → q=1000,0100,0010,0001,1000,… idx=3,2,1,0,3; busy=1; done never.
2. N=4, dwell=2, mode=1, dir=1 → q=0001×3, 0010×3, 0100×3, 1000×3 cycles, then 0000 with done=1 for one cycle, busy=0.
3. Pause: continuous dwell=0, drop en for 3 cycles while q=0100 → q stays 0100 for those cycles, then resumes at 0010; change dwell/dir mid-run → no effect.
4. Abort: stop while q=0010 → next cycle q=0000, busy=0, done=0; start and stop in same cycle from IDLE → stays IDLE.
5. Reset mid-run (rst=1 while q=1000, counter>0) → after edge q=0, idx=0, busy=0, done=0; next start restarts at first channel with full dwell.
6. N=8, DWELL_W=4, dwell=15, single-shot, dir=0 → 8 slots × 16 cycles = 128 cycles of busy, q walks 10000000→00000001, then a single done pulse; one-hot assertion holds throughout.
